// File: rtl/hi_lo_unit.sv
// hi_lo_unit: iterative multiply/divide engine that owns the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a final
// sign-fixup cycle before HI/LO are written.
module hi_lo_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // |multiplicand| or |divisor|
   logic [WIDTH-1:0]   orig_a_q, orig_a_d; // unmodified dividend for divide-by-zero
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               is_signed;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh, rem_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Operand magnitudes and one iteration of each datapath.
   always_comb begin
      is_signed = (op == OpMult) || (op == OpDiv);
      abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
      abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, opnd_q};
      // Borrow out of the trial subtract means the divisor did not fit.
      div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

      prod_fix = neg_res_q ? -acc_q : acc_q;
      quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // FSM next-state, operand capture and HI/LO write selection.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      orig_a_d  = orig_a_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               case (op)
                  OpMthi: hi_d = a;
                  OpMtlo: lo_d = a;
                  OpMult, OpMultu, OpDiv, OpDivu: begin
                     is_div_d  = op[1];
                     orig_a_d  = a;
                     neg_res_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_rem_d = is_signed && a[WIDTH-1];
                     cnt_d     = '0;
                     state_d   = StCalc;
                     if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                     end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StCalc: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (!is_div_q) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (opnd_q == '0) begin
               hi_d = orig_a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         orig_a_q  <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         orig_a_q  <= orig_a_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Directed bench for hi_lo_unit: arithmetic results, latency, moves,
// ignored starts while busy, and asynchronous reset mid-operation.
module tb_hi_lo_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   hi_lo_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // Issue one op; return busy-cycle count before done, count of busy-low
   // cycles seen before done, and whether hi/lo moved before done.
   // Entered and left 1 time unit after a rising edge.
   task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int lat, output int not_busy, output bit moved);
      logic [31:0] pre_hi, pre_lo;
      pre_hi = hi;
      pre_lo = lo;
      lat = 0;
      not_busy = 0;
      moved = 1'b0;
      start = 1'b1; op = o; a = va; b = vb;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      while (!done && lat < 40) begin
         if (!busy) not_busy++;
         if (hi !== pre_hi || lo !== pre_lo) moved = 1'b1;
         lat++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
      #12;
      tests++;
      if ({hi, lo, busy, done} !== 66'd0) begin
         fails++;
         $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, want all 0", hi, lo, busy, done);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_multu_latency;
      int lat, nb; bit mv;
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, mv);
      tests++;
      if (lat !== 33 || nb !== 0) begin
         fails++;
         $display("FAIL multu_latency: busy_cycles=%0d busy_low=%0d, want 33 and 0", lat, nb);
      end
      tests++;
      if (mv !== 1'b0) begin
         fails++;
         $display("FAIL multu_hilo_hold: hi/lo changed before done, want stable");
      end
      tests++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || busy !== 1'b0) begin
         fails++;
         $display("FAIL multu_result: hi=%h lo=%h busy=%b, want fffffffe 00000001 0", hi, lo, busy);
      end
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_pulse_width: done=%b one cycle later, want 0", done);
      end
   endtask

   task automatic test_arith;
      logic [2:0]  v_op[6]  = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
      logic [31:0] v_a[6]   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100,
                                32'h80000000, 32'd100};
      logic [31:0] v_b[6]   = '{32'd5, 32'h80000000, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
      logic [31:0] v_hi[6]  = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd100};
      logic [31:0] v_lo[6]  = '{32'hFFFFFFF1, 32'h0, 32'hFFFFFFFD, 32'd14, 32'h80000000,
                                32'hFFFFFFFF};
      int lat, nb; bit mv;
      for (int i = 0; i < 6; i++) begin
         run_op(v_op[i], v_a[i], v_b[i], lat, nb, mv);
         tests++;
         if (hi !== v_hi[i] || lo !== v_lo[i] || lat !== 33 || done !== 1'b1) begin
            fails++;
            $display("FAIL arith_%0d: hi=%h lo=%h lat=%0d done=%b, want %h %h 33 1",
                     i, hi, lo, lat, done, v_hi[i], v_lo[i]);
         end
      end
   endtask

   task automatic test_moves;
      start = 1'b1; op = 3'd4; a = 32'h1234;
      @(posedge clk); #1;
      tests++;
      if (hi !== 32'h1234 || busy !== 1'b0) begin
         fails++;
         $display("FAIL mthi: hi=%h busy=%b, want 00001234 0", hi, busy);
      end
      op = 3'd5; a = 32'h5678;
      @(posedge clk); #1;
      tests++;
      if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, want 1234 5678 0 0",
                  hi, lo, busy, done);
      end
      op = 3'd6; a = 32'hAAAA;
      @(posedge clk); #1;
      op = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
      tests++;
      if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
         fails++;
         $display("FAIL noop: hi=%h lo=%h busy=%b, want 1234 5678 0", hi, lo, busy);
      end
   endtask

   task automatic test_ignore_while_busy;
      int lat;
      start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         if (lat == 4) begin
            start = 1'b1; op = 3'd5; a = 32'hDEAD;
         end else if (lat == 5) begin
            op = 3'd3; a = 32'd99; b = 32'd4;
         end else begin
            start = 1'b0;
         end
         lat++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      tests++;
      if (hi !== 32'd0 || lo !== 32'd42 || lat !== 33) begin
         fails++;
         $display("FAIL ignore_busy: hi=%h lo=%h lat=%0d, want 0 42 33", hi, lo, lat);
      end
   endtask

   task automatic test_reset_mid;
      int pulses, lat, nb; bit mv;
      start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      tests++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0",
                  hi, lo, busy, done);
      end
      @(posedge clk); #2 reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      tests++;
      if (pulses !== 0) begin
         fails++;
         $display("FAIL reset_no_done: %0d busy/done cycles after reset, want 0", pulses);
      end
      run_op(3'd1, 32'd2, 32'd3, lat, nb, mv);
      tests++;
      if (hi !== 32'd0 || lo !== 32'd6 || lat !== 33) begin
         fails++;
         $display("FAIL post_reset_multu: hi=%h lo=%h lat=%0d, want 0 6 33", hi, lo, lat);
      end
   endtask

   initial begin
      test_reset();
      test_multu_latency();
      test_arith();
      test_moves();
      test_ignore_while_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
